// File: rtl/io_type_out.sv
// Slow-output typewriter stage: turns OF character-class decodes into a paced
// character handshake. Optional odd parity on TW_CODE when G15_TYPE_PARITY_EN is defined.
module io_type_out #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       TF,
  input  logic       SLOW_OUT,
  input  logic       OG,
  input  logic       OF1,
  input  logic       DIGIT_OF,
  input  logic       SIGN_OF,
  input  logic       CR_TAB_OF,
  input  logic       WAIT_OF,
  input  logic [3:0] OB_DIGIT,
  input  logic       SIGN_NEG,
  input  logic       READY,
  input  logic       TW_READY,
  output logic [5:0] TW_CODE,
  output logic       TW_VALID,
  output logic       TW_PAR,
  output logic       TYPE_FB,
  output logic       TW_BUSY,
  output logic       TW_OVERRUN
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] C_DIGIT = 2'd0;
  localparam logic [1:0] C_SIGN  = 2'd1;
  localparam logic [1:0] C_CRTAB = 2'd2;
  localparam logic [1:0] C_WAIT  = 2'd3;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  // WAIT skips the SEND handshake; one extra pacing cycle keeps its TYPE_FB
  // aligned with a character accepted on its first SEND cycle.
  localparam logic [7:0] WAIT_LD = 8'(HOLD_CYCLES);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] code_q, code_d;
  logic [1:0] cls_q, cls_d;
  logic [3:0] dig_q, dig_d;
  logic       neg_q, neg_d;
  logic       of1_q, of1_d;
  logic       ovr_q, ovr_d;
  logic       req;
  logic [1:0] cls_sel;

  assign req = TF & SLOW_OUT & OG & (DIGIT_OF | SIGN_OF | CR_TAB_OF | WAIT_OF);

  always_comb begin
    cls_sel = C_DIGIT;
    if (WAIT_OF)        cls_sel = C_WAIT;
    else if (CR_TAB_OF) cls_sel = C_CRTAB;
    else if (SIGN_OF)   cls_sel = C_SIGN;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    cls_d   = cls_q;
    dig_d   = dig_q;
    neg_d   = neg_q;
    of1_d   = of1_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cls_d   = cls_sel;
          dig_d   = OB_DIGIT;
          neg_d   = SIGN_NEG;
          of1_d   = OF1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        case (cls_q)
          C_DIGIT: code_d = {2'b00, dig_q};
          C_SIGN:  code_d = neg_q ? 6'h2D : 6'h20;
          C_CRTAB: code_d = of1_q ? 6'h0D : 6'h09;
          default: code_d = code_q;
        endcase
        if (cls_q == C_WAIT) begin
          state_d = S_HOLD;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (TW_READY) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (req && state_q != S_IDLE) ovr_d = 1'b1;
    // Cancel wins over everything, including a request in the same cycle.
    if (READY) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      code_d  = code_q;
      cls_d   = cls_q;
      dig_d   = dig_q;
      neg_d   = neg_q;
      of1_d   = of1_q;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      code_q  <= 6'h00;
      cls_q   <= C_DIGIT;
      dig_q   <= 4'h0;
      neg_q   <= 1'b0;
      of1_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      cls_q   <= cls_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
      of1_q   <= of1_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef G15_TYPE_PARITY_EN
  logic par_q;
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ~^code_d;
  end
  assign TW_PAR = par_q;
`else
  assign TW_PAR = 1'b0;
`endif

  assign TW_CODE    = code_q;
  assign TW_VALID   = (state_q == S_SEND);
  assign TYPE_FB    = (state_q == S_DONE) & ~READY;
  assign TW_BUSY    = (state_q != S_IDLE);
  assign TW_OVERRUN = ovr_q;

endmodule

// File: tb/tb_io_type_out.sv
// Directed-vector bench for io_type_out at HOLD_CYCLES=16.
module tb_io_type_out;
  logic       CLOCK, rst_n, TF, SLOW_OUT, OG, OF1;
  logic       DIGIT_OF, SIGN_OF, CR_TAB_OF, WAIT_OF;
  logic [3:0] OB_DIGIT;
  logic       SIGN_NEG, READY, TW_READY;
  logic [5:0] TW_CODE;
  logic       TW_VALID, TW_PAR, TYPE_FB, TW_BUSY, TW_OVERRUN;

  int nvec = 0, nerr = 0;
  int cyc = 0, n = 0, n0;
  int vseen, vfirst, unstable, fbcnt;
  logic [5:0] code_seen;
  logic       par_seen;

  io_type_out #(.HOLD_CYCLES(16)) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .TF(TF), .SLOW_OUT(SLOW_OUT), .OG(OG), .OF1(OF1),
    .DIGIT_OF(DIGIT_OF), .SIGN_OF(SIGN_OF), .CR_TAB_OF(CR_TAB_OF), .WAIT_OF(WAIT_OF),
    .OB_DIGIT(OB_DIGIT), .SIGN_NEG(SIGN_NEG), .READY(READY), .TW_READY(TW_READY),
    .TW_CODE(TW_CODE), .TW_VALID(TW_VALID), .TW_PAR(TW_PAR), .TYPE_FB(TYPE_FB),
    .TW_BUSY(TW_BUSY), .TW_OVERRUN(TW_OVERRUN)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [5:0] c);
`ifdef G15_TYPE_PARITY_EN
    return ~^c;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
    cyc++;
  endtask

  // One-cycle TF pulse with the given decodes; n marks the request cycle.
  task automatic send_req(input logic d, s, c, w, of1, neg, input logic [3:0] dig);
    TF = 1; DIGIT_OF = d; SIGN_OF = s; CR_TAB_OF = c; WAIT_OF = w;
    OF1 = of1; SIGN_NEG = neg; OB_DIGIT = dig;
    n = cyc;
    tick();
    TF = 0; DIGIT_OF = 0; SIGN_OF = 0; CR_TAB_OF = 0; WAIT_OF = 0;
  endtask

  task automatic wait_fb(input string tag, input int exp_lat);
    vseen = 0; vfirst = -1; unstable = 0; code_seen = 6'h00; par_seen = 1'b0;
    while (!TYPE_FB && (cyc - n) < 100) begin
      if (TW_VALID) begin
        if (vseen == 0) begin
          vfirst = cyc - n; code_seen = TW_CODE; par_seen = TW_PAR;
        end else if (TW_CODE !== code_seen) unstable = 1;
        vseen++;
      end
      tick();
    end
    chk({tag, ".fb_lat"}, cyc - n, exp_lat);
    tick();
    chk({tag, ".fb_1cyc"}, {31'b0, TYPE_FB}, 0);
    chk({tag, ".idle"}, {31'b0, TW_BUSY}, 0);
  endtask

  task automatic run_vec(input string tag, input logic d, s, c, w, of1, neg,
                         input logic [3:0] dig, input logic [5:0] exp_code);
    send_req(d, s, c, w, of1, neg, dig);
    wait_fb(tag, 19);
    if (w) begin
      chk({tag, ".novalid"}, vseen, 0);
    end else begin
      chk({tag, ".vfirst"}, vfirst, 2);
      chk({tag, ".vcnt"}, vseen, 1);
      chk({tag, ".code"}, {26'b0, code_seen}, {26'b0, exp_code});
      chk({tag, ".par"}, {31'b0, par_seen}, {31'b0, exp_par(exp_code)});
    end
  endtask

  initial begin
    rst_n = 0; TF = 0; SLOW_OUT = 1; OG = 1; OF1 = 0;
    DIGIT_OF = 0; SIGN_OF = 0; CR_TAB_OF = 0; WAIT_OF = 0;
    OB_DIGIT = 0; SIGN_NEG = 0; READY = 0; TW_READY = 1;
    #12;
    chk("rst.code", {26'b0, TW_CODE}, 0);
    chk("rst.out", {27'b0, TW_VALID, TW_PAR, TYPE_FB, TW_BUSY, TW_OVERRUN}, 0);
    rst_n = 1;
    tick();

    // Main character classes and decode priority.
    run_vec("dig7",     1, 0, 0, 0, 0, 0, 4'h7, 6'h07);
    run_vec("sign_pos", 0, 1, 0, 0, 0, 0, 4'h0, 6'h20);
    run_vec("cr",       0, 0, 1, 0, 1, 0, 4'h0, 6'h0D);
    run_vec("tab",      0, 0, 1, 0, 0, 0, 4'h0, 6'h09);
    run_vec("pri_sd",   1, 1, 0, 0, 0, 1, 4'h5, 6'h2D);
    run_vec("pri_cd",   1, 0, 1, 0, 1, 0, 4'h5, 6'h0D);
    run_vec("digF",     1, 0, 0, 0, 0, 0, 4'hF, 6'h0F);
    run_vec("wait",     0, 0, 0, 1, 0, 0, 4'h0, 6'h00);
    run_vec("pri_wd",   1, 1, 0, 1, 0, 1, 4'h3, 6'h00);

    // Adapter stalls five cycles: six valid cycles, code stable.
    TW_READY = 0;
    send_req(0, 1, 0, 0, 0, 1, 4'h0);
    fork
      begin
        wait (cyc - n == 7);
        #1 TW_READY = 1;
      end
    join_none
    wait_fb("stall", 24);
    chk("stall.vcnt", vseen, 6);
    chk("stall.code", {26'b0, code_seen}, 32'h2D);
    chk("stall.stable", unstable, 0);
    chk("stall.par", {31'b0, par_seen}, {31'b0, exp_par(6'h2D)});

    // Requests that must be ignored.
    send_req(0, 0, 0, 0, 1, 1, 4'h9);
    chk("nodec.busy", {31'b0, TW_BUSY}, 0);
    SLOW_OUT = 0;
    send_req(1, 0, 0, 0, 0, 0, 4'h9);
    chk("noslow.busy", {31'b0, TW_BUSY}, 0);
    SLOW_OUT = 1;

    // Overrun during HOLD leaves the first character intact.
    send_req(1, 0, 0, 0, 0, 0, 4'h3);
    repeat (7) tick();
    n0 = n;
    send_req(1, 0, 0, 0, 0, 0, 4'h9);
    n = n0;
    chk("ovr.flag", {31'b0, TW_OVERRUN}, 1);
    chk("ovr.code", {26'b0, TW_CODE}, 32'h03);
    wait_fb("ovr", 19);
    chk("ovr.sticky", {31'b0, TW_OVERRUN}, 1);
    READY = 1; tick(); READY = 0;
    chk("ovr.clr", {31'b0, TW_OVERRUN}, 0);

    // READY together with a request: cancel wins.
    READY = 1;
    send_req(1, 0, 0, 0, 0, 0, 4'h4);
    READY = 0;
    chk("rdyreq.busy", {31'b0, TW_BUSY}, 0);
    chk("rdyreq.ovr", {31'b0, TW_OVERRUN}, 0);
    send_req(1, 0, 0, 0, 0, 0, 4'h4);
    repeat (5) tick();
    READY = 1;
    send_req(1, 0, 0, 0, 0, 0, 4'h6);
    READY = 0;
    chk("rdybusy.busy", {31'b0, TW_BUSY}, 0);
    chk("rdybusy.ovr", {31'b0, TW_OVERRUN}, 0);

    // READY during SEND aborts with no feedback.
    TW_READY = 0;
    send_req(1, 0, 0, 0, 0, 0, 4'h2);
    tick();
    chk("cancel.valid_pre", {31'b0, TW_VALID}, 1);
    READY = 1; tick(); READY = 0;
    chk("cancel.valid", {31'b0, TW_VALID}, 0);
    chk("cancel.busy", {31'b0, TW_BUSY}, 0);
    fbcnt = 0;
    repeat (25) begin
      if (TYPE_FB) fbcnt++;
      tick();
    end
    chk("cancel.nofb", fbcnt, 0);

    // Reset during SEND drops valid at once.
    send_req(1, 0, 0, 0, 0, 0, 4'h8);
    tick();
    #2 rst_n = 0;
    #1;
    chk("rstsend.valid", {31'b0, TW_VALID}, 0);
    chk("rstsend.busy", {31'b0, TW_BUSY}, 0);
    tick();
    rst_n = 1;
    TW_READY = 1;
    tick();

    // Reset mid-HOLD with overrun set: everything clears immediately.
    send_req(1, 0, 0, 0, 0, 0, 4'hA);
    repeat (4) tick();
    send_req(1, 0, 0, 0, 0, 0, 4'h1);
    chk("rsthold.pre_ovr", {31'b0, TW_OVERRUN}, 1);
    chk("rsthold.pre_code", {26'b0, TW_CODE}, 32'h0A);
    #2 rst_n = 0;
    #1;
    chk("rsthold.code", {26'b0, TW_CODE}, 0);
    chk("rsthold.out", {27'b0, TW_VALID, TW_PAR, TYPE_FB, TW_BUSY, TW_OVERRUN}, 0);
    tick();
    rst_n = 1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/io_type_out.md
IO_TYPE_OUT -- requirements
Module: io_type_out

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, typewriter mechanical pacing in CLOCK cycles after each character transfer; legal range 1..255.
REQ-002 CLOCK  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset; one clock, reset asynchronous active-low.
REQ-004 TF  in  1  end-of-word-time pulse, one CLOCK wide.
REQ-005 SLOW_OUT, OG  in  1 each  slow-output mode and precession-control flip-flop from the I/O control stage.
REQ-006 OF1, DIGIT_OF, SIGN_OF, CR_TAB_OF, WAIT_OF  in  1 each  OF character-class decodes from the I/O control stage.
REQ-007 OB_DIGIT  in  4  digit value precessed into OB (OB5 = MSB .. OB2 = LSB).
REQ-008 SIGN_NEG  in  1  sign of current word, 1 = negative.
REQ-009 READY  in  1  I/O section ready/cancel.
REQ-010 TW_READY  in  1  typewriter adapter accepts character.
REQ-011 TW_CODE  out  6  typewriter character code.
REQ-012 TW_VALID  out  1  TW_CODE valid.
REQ-013 TW_PAR  out  1  odd parity over TW_CODE.
REQ-014 TYPE_FB  out  1  one-cycle character-complete feedback, consumed upstream as KEY_FB.
REQ-015 TW_BUSY  out  1  high in every state except IDLE.
REQ-016 TW_OVERRUN  out  1  sticky: request arrived while busy.

Function
REQ-017 States SHALL be IDLE, LOAD, SEND, HOLD, DONE.
REQ-018 Request SHALL be TF & SLOW_OUT & OG & (DIGIT_OF | SIGN_OF | CR_TAB_OF | WAIT_OF); TF with none of these decodes SHALL be ignored.
REQ-019 In IDLE, request SHALL capture OB_DIGIT, SIGN_NEG, OF1 and the class decodes, then go to LOAD.
REQ-020 Decode priority SHALL be WAIT_OF > CR_TAB_OF > SIGN_OF > DIGIT_OF.
REQ-021 LOAD (1 cycle) SHALL form the code: digit -> {2'b00, OB_DIGIT}; sign -> 6'h2D if negative else 6'h20; CR_TAB with OF1=1 -> 6'h0D, OF1=0 -> 6'h09.
REQ-022 LOAD SHALL go to HOLD for WAIT class, otherwise to SEND.
REQ-023 SEND SHALL hold TW_VALID=1 and TW_CODE stable until the cycle where TW_READY=1, then go to HOLD.
REQ-024 TW_VALID SHALL be 0 in every state except SEND.
REQ-025 HOLD SHALL load an 8-bit counter with HOLD_CYCLES-1 on entry, decrement each cycle, and exit to DONE in the cycle it reads 0.
REQ-026 DONE SHALL assert TYPE_FB for exactly one cycle, then return to IDLE.
REQ-027 Latency: request at cycle n, TW_READY held high -> TW_VALID at n+2, TYPE_FB at n+3+HOLD_CYCLES.
REQ-028 Request in any state other than IDLE SHALL set TW_OVERRUN and SHALL NOT disturb the character in flight.
REQ-029 READY=1 in any state SHALL force IDLE at the next edge, clear TW_OVERRUN, and suppress TYPE_FB.
REQ-030 Simultaneous READY and request SHALL resolve to READY: no capture, no overrun.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, counter 0, TW_CODE 6'h00, TW_VALID 0, TW_PAR 0, TYPE_FB 0, TW_BUSY 0, TW_OVERRUN 0.
REQ-032 Reset during SEND SHALL drop TW_VALID without a transfer.

Configuration
REQ-033 With G15_TYPE_PARITY_EN defined, TW_PAR SHALL equal ~^TW_CODE and is registered with TW_CODE.
REQ-034 With G15_TYPE_PARITY_EN undefined, TW_PAR SHALL be constant 0 and no parity logic is built.

Verification
REQ-035 DIGIT_OF, OB_DIGIT=4'h7, TW_READY=1, HOLD_CYCLES=16 -> TW_CODE=6'h07 with TW_VALID at n+2, TYPE_FB at n+19.
REQ-036 SIGN_OF with SIGN_NEG=1, TW_READY low 5 cycles -> TW_VALID high 6 cycles with TW_CODE=6'h2D stable; with parity enabled TW_PAR=1.
REQ-037 WAIT_OF -> TW_VALID never asserts; TYPE_FB at n+3+HOLD_CYCLES.
REQ-038 Second request during HOLD -> TW_OVERRUN=1; first character completes normally; READY clears the flag.
REQ-039 READY during SEND -> IDLE next cycle, TW_VALID=0, no TYPE_FB; rst_n low mid-HOLD -> all outputs 0 immediately.
